// File: rtl/uart_cmd_rx_pkg.sv
// uart_cmd_rx_pkg
//   Shared definitions for the command UART receiver: FSM state encoding
//   and default parameter values (100 MHz clock, 115200 baud, 'S' command).
package uart_cmd_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_e;

    localparam int         DEF_CLKS_PER_BIT = 868;
    localparam logic [7:0] DEF_START_CMD    = 8'h53;

endpackage

// File: rtl/uart_cmd_rx_if.sv
// uart_cmd_rx_if
//   Serial input plus decoded-byte outputs of the command receiver.
//   master : host/line side (drives rx_in, observes results)
//   slave  : receiver side (samples rx_in, drives results)
//   rx_in     serial line, idle high
//   rx_data   last correctly framed byte
//   rx_valid  one-cycle strobe, rx_data updated
//   frame_err one-cycle strobe, stop bit sampled low
//   tx_start  one-cycle strobe, received byte matched the start command
//   busy      receiver not idle
interface uart_cmd_rx_if;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       tx_start;
    logic       busy;

    modport master (output rx_in,
                    input  rx_data, rx_valid, frame_err, tx_start, busy);
    modport slave  (input  rx_in,
                    output rx_data, rx_valid, frame_err, tx_start, busy);
endinterface

// File: rtl/uart_bit_sync.sv
// uart_bit_sync
//   Two-flop synchronizer for an asynchronous, idle-high line.
//   clk   system clock
//   rst_n async active-low reset; both flops reset to 1 (line idle)
//   d     asynchronous input
//   q     synchronized output, two cycles of latency
module uart_bit_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb sync_d = {sync_q[0], d};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= sync_d;
    end

    assign q = sync_q[1];
endmodule

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx
//   8N1 UART receiver. Each correctly framed byte is presented on rx_data
//   with a one-cycle rx_valid strobe; a byte equal to START_CMD also pulses
//   tx_start. A low stop bit pulses frame_err and the receiver then waits
//   for the line to return high before accepting another frame.
//   clk    system clock (posedge)
//   rst_n  async active-low reset
//   bus    uart_cmd_rx_if.slave (rx_in in; rx_data/rx_valid/frame_err/
//          tx_start/busy out)
module uart_cmd_rx
    import uart_cmd_rx_pkg::*;
#(
    parameter int         CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter logic [7:0] START_CMD    = DEF_START_CMD
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_cmd_rx_if.slave  bus
);
    localparam logic [15:0] CNT_FULL = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] CNT_HALF = 16'(CLKS_PER_BIT / 2 - 1);

    logic        rx_s;
    state_e      state_q,     state_d;
    logic [15:0] cnt_q,       cnt_d;
    logic [2:0]  bit_idx_q,   bit_idx_d;
    logic [7:0]  shift_q,     shift_d;
    logic [7:0]  rx_data_q,   rx_data_d;
    logic        rx_valid_q,  rx_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        tx_start_q,  tx_start_d;

    uart_bit_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.rx_in),
        .q     (rx_s)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 16'd1;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        tx_start_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = ST_START;
            end
            // Re-check the start bit at its midpoint to reject glitches;
            // this also aligns later samples to bit centres.
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_DATA;
                        bit_idx_d = 3'd0;
                    end
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;                      // next bit, same state
                    shift_d = {rx_s, shift_q[7:1]};    // LSB arrives first
                    if (bit_idx_q == 3'd7) state_d = ST_STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    if (rx_s) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        tx_start_d = (shift_q == START_CMD);
                        state_d    = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                cnt_d = '0;
                if (rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            tx_start_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            tx_start_q  <= tx_start_d;
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx
//   Drives 8N1 frames (directed cases then random bytes, stop bits and
//   gaps) and compares strobe counts and rx_data against a frame-level
//   model: good stop -> one rx_valid (+tx_start if byte == command),
//   bad stop -> one frame_err and rx_data keeps the last good byte.
module tb_uart_cmd_rx;
    localparam int         CPB = 16;
    localparam logic [7:0] CMD = 8'h53;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_cmd_rx_if bus ();

    uart_cmd_rx #(.CLKS_PER_BIT(CPB), .START_CMD(CMD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Strobe monitor: counts high cycles, so a stretched pulse shows up
    // as an extra count.
    int n_valid = 0, n_ferr = 0, n_txs = 0, n_both = 0, n_txs_lone = 0;
    always @(negedge clk) begin
        if (bus.rx_valid)                  n_valid++;
        if (bus.frame_err)                 n_ferr++;
        if (bus.tx_start)                  n_txs++;
        if (bus.rx_valid && bus.frame_err) n_both++;
        if (bus.tx_start && !bus.rx_valid) n_txs_lone++;
    end

    logic [7:0] model_data;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v);
        bus.rx_in = v;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] b, input logic ok);
        int v0, f0, t0;
        v0 = n_valid; f0 = n_ferr; t0 = n_txs;
        send_frame(b, ok);
        if (ok) model_data = b;
        chk({tag, ".valid"}, n_valid - v0, ok ? 1 : 0);
        chk({tag, ".ferr"},  n_ferr - f0,  ok ? 0 : 1);
        chk({tag, ".txs"},   n_txs - t0,   (ok && b == CMD) ? 1 : 0);
        chk({tag, ".data"},  bus.rx_data,  model_data);
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int k;
        k = 0;
        while (bus.busy && k < lim) begin
            tick(1);
            k++;
        end
        chk(tag, bus.busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, f0, t0, lowcnt, seen;
        logic [7:0] b;
        logic ok;

        bus.rx_in  = 1'b1;
        rst_n      = 1'b0;
        model_data = 8'h00;
        tick(3);
        chk("rst.data",  bus.rx_data,   8'h00);
        chk("rst.valid", bus.rx_valid,  0);
        chk("rst.ferr",  bus.frame_err, 0);
        chk("rst.txs",   bus.tx_start,  0);
        chk("rst.busy",  bus.busy,      0);
        rst_n = 1'b1;
        tick(5);

        // Plain byte, then command byte with a bad stop bit, then good.
        check_frame("a5", 8'hA5, 1'b1);
        tick(4);
        check_frame("53bad", CMD, 1'b0);
        bus.rx_in = 1'b0;
        lowcnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (!bus.busy) lowcnt++;
        end
        chk("break.busy_held", lowcnt, 0);
        bus.rx_in = 1'b1;
        wait_idle("break.release", 10);
        tick(2);
        check_frame("53", CMD, 1'b1);
        tick(3);

        // Short low glitch on an idle line.
        v0 = n_valid; f0 = n_ferr; t0 = n_txs;
        seen = 0;
        bus.rx_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (bus.busy) seen = 1;
        end
        bus.rx_in = 1'b1;
        wait_idle("glitch.idle", 10);
        chk("glitch.seen_busy", seen, 1);
        chk("glitch.strobes", (n_valid - v0) + (n_ferr - f0) + (n_txs - t0), 0);
        tick(3);

        // Back-to-back frames, no idle gap.
        check_frame("b2b0", 8'h00, 1'b1);
        check_frame("b2b1", 8'hFF, 1'b1);
        tick(3);

        // Reset in the middle of data bit 4.
        b = CMD;
        v0 = n_valid; f0 = n_ferr; t0 = n_txs;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        bus.rx_in = b[4];
        tick(CPB / 2);
        rst_n = 1'b0;
        model_data = 8'h00;
        tick(1);
        chk("mid_rst.data", bus.rx_data, 8'h00);
        chk("mid_rst.busy", bus.busy, 0);
        bus.rx_in = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(CPB * 10);
        chk("mid_rst.strobes", (n_valid - v0) + (n_ferr - f0) + (n_txs - t0), 0);
        check_frame("41", 8'h41, 1'b1);
        tick(2);

        // Random traffic.
        for (int f = 0; f < 24; f++) begin
            b  = ($urandom_range(0, 3) == 0) ? CMD : 8'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            check_frame($sformatf("rnd%0d", f), b, ok);
            if (!ok) begin
                bus.rx_in = 1'b0;
                tick($urandom_range(0, 20));
                bus.rx_in = 1'b1;
                wait_idle($sformatf("rnd%0d.idle", f), 10);
            end else begin
                tick($urandom_range(0, 3));
            end
        end

        tick(5);
        chk("never_valid_and_ferr", n_both, 0);
        chk("txs_only_with_valid", n_txs_lone, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
